// File: rtl/universal_shift_reg_pkg.sv
// Shared types for the universal shift register: command codes and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_LOAD = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/universal_shift_reg_if.sv
// Command/status bundle of the universal shift register.
// The master drives commands and serial inputs; the slave (the register) returns q and status.
interface universal_shift_reg_if #(parameter int WIDTH = 8);
  import usr_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  op_t              op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] load_data;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  modport master (
    output start, op, count, load_data, sin_l, sin_r,
    input  q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  start, op, count, load_data, sin_l, sin_r,
    output q, sout_l, sout_r, busy, done
  );

endinterface

// File: rtl/universal_shift_reg_shift_step.sv
// Next value of the register after a single shift/rotate step; purely combinational.
// LOAD is resolved by the caller, so it (like HOLD) leaves q untouched here.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_t              op,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      OP_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLR:  q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register, one step per clock under start/busy/done.
// N-step commands finish N+1 cycles after accept; start is only honoured in IDLE.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  universal_shift_reg_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nxt;
  op_t              op_r;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_step;
  logic             accept;
  logic             immediate;

  assign accept    = (state == IDLE) && bus.start;
  // Commands that need no stepping go straight to DONE.
  assign immediate = (bus.op == OP_HOLD) || (bus.op == OP_LOAD) ||
                     (bus.op == OP_CLR)  || (bus.count == '0);

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q      (q_r),
    .op     (op_r),
    .sin_l  (bus.sin_l),
    .sin_r  (bus.sin_r),
    .q_next (q_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = immediate ? DONE : RUN;
      RUN:     if (remaining == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:  bus.busy = 1'b1;
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r       <= '0;
      remaining <= '0;
      op_r      <= OP_HOLD;
    end else if (accept) begin
      op_r      <= bus.op;
      remaining <= bus.count;
      if (bus.op == OP_LOAD)     q_r <= bus.load_data;
      else if (bus.op == OP_CLR) q_r <= '0;
    end else if (state == RUN) begin
      q_r       <= q_step;
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign bus.q      = q_r;
  assign bus.sout_l = q_r[WIDTH-1];
  assign bus.sout_r = q_r[0];

endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register that grows the single-bit bidirectional shifter into a WIDTH-bit register. It supports parallel load, logical and arithmetic shifts, rotates and clear. Each command carries a step count and is executed one bit position per clock under a start/busy/done handshake. It sits wherever serial/parallel conversion or multi-position shifting is needed, with serial inputs and outputs at both ends.

## Interface

- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), step-count width (derived; do not override)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  command request; sampled only in IDLE
- op  in  3  command code (see Operation)
- count  in  CNT_W  number of shift/rotate steps
- load_data  in  WIDTH  parallel load value
- sin_l  in  1  serial in at MSB end (used by shift right)
- sin_r  in  1  serial in at LSB end (used by shift left)
- q  out  WIDTH  register contents
- sout_l  out  1  q[WIDTH-1], combinational
- sout_r  out  1  q[0], combinational
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation

- Op codes:
  - 000: HOLD
  - 001: SHL, q = {q[W-2:0], sin_r}
  - 010: SHR, q = {sin_l, q[W-1:1]}
  - 011: ROL
  - 100: ROR
  - 101: LOAD, q = load_data
  - 110: ASR, q = {q[W-1], q[W-1:1]}
  - 111: CLR, q = 0
- FSM states:
  - IDLE: start=1 accepts command; op and count latched at that edge.
  - RUN: one step per edge; remaining-step counter decrements; last step → DONE.
  - DONE: one cycle → IDLE.
- IDLE transitions on accept:
  - LOAD/CLR: q updated at the accept edge → DONE.
  - HOLD, or any shift/rotate with count=0: q unchanged → DONE.
  - Shift/rotate with count=N>0: → RUN with remaining=N.
- count is honoured literally up to 2^CNT_W-1. No clamping: SHL by >WIDTH flushes fully with sin_r bits; ROL by WIDTH restores q.
- sin_l/sin_r are sampled live on every RUN edge, not latched at accept.
- start, op, count and load_data are ignored outside IDLE. start in DONE is not queued.
- Reset (rst=0): q=0, busy=0, done=0, state IDLE, counter=0, asynchronously. Reset mid-RUN aborts the command; no done is produced.

## Timing

- busy=1 in RUN and DONE; done=1 in DONE only; both 0 in IDLE and during reset.
- Shift/rotate with N steps: q changes on edges 1..N after the accept edge; done high during cycle N+1; next command accepted at earliest at edge N+2.
- LOAD/CLR/HOLD/count=0: done high the cycle after the accept edge. Minimum command spacing is 2 cycles.
- sout_l/sout_r follow q with no added latency.

## Structure

- Package usr_pkg:
  - op_t enum of the eight op codes
  - state_t enum {IDLE, RUN, DONE}
- Sub-module usr_shift_step: combinational next-q for one step, taking q, op, sin_l and sin_r. It is reused by the RUN datapath and by the bench's reference model.
- Top level holds the FSM, the remaining-step counter and the q register.

## Test plan

- Reset: rst=0 with arbitrary inputs → q=00, busy=0, done=0; release, idle → no change.
- LOAD 0xA5 → q=A5 at the accept edge; busy=1 and done=1 in the next cycle; then IDLE.
- SHL count=3, sin_r=1, from A5 → q=4B, 97, 2F on successive edges; done in cycle 4; a start pulse during busy is ignored.
- ROR count=8 from 2F → q returns to 2F after 8 edges; done in cycle 9; sout_r tracks q[0] each cycle.
- ASR count=2 from 0x90 → C8 then E4. SHR count=2, sin_l=0, from 0x90 → 48 then 24.
- SHL count=5 with rst asserted after 2 steps → q=00 immediately, busy=0, no done pulse. SHL count=0 → q unchanged, done next cycle.
